cva6_accel_predecode_buffer: RTL and testbench

- Parametrised successor to the combinational CVA6 accelerator first-pass decoder.
- Buffers fetched instructions in a Depth-entry FIFO and predecodes each one on push, storing the flag vector with it.
- Presents instructions in order to the CVA6 accelerator dispatcher.
- Throttles accelerator instructions with an outstanding-instruction credit counter and a vector-config (vset*) serialisation FSM.

---
 rtl/ara_pkg.sv | 73 +++++++
 rtl/cva6_accel_predecode_unit.sv | 78 +++++++
 rtl/cva6_accel_predecode_buffer.sv | 106 ++++++++++
 tb/tb_cva6_accel_predecode_buffer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ara_pkg.sv
// Shared types and encodings for the CVA6 accelerator predecode buffer.
package ara_pkg;

    typedef struct packed {
        logic accel;
        logic rs1;
        logic rs2;
        logic rd;
        logic fs1;
        logic fs2;
        logic fd;
        logic vfp;
        logic load;
        logic store;
        logic cfg;
    } predecode_flags_t;

    typedef struct packed {
        logic [31:0]      instr;
        predecode_flags_t flags;
    } fifo_entry_t;

    localparam logic [6:0] OpcodeVec     = 7'b1010111;
    localparam logic [6:0] OpcodeLoadFp  = 7'b0000111;
    localparam logic [6:0] OpcodeStoreFp = 7'b0100111;
    localparam logic [6:0] OpcodeSystem  = 7'b1110011;
    localparam logic [6:0] OpcodeAmo     = 7'b0101111;

    localparam logic [2:0] OPIVV = 3'b000;
    localparam logic [2:0] OPFVV = 3'b001;
    localparam logic [2:0] OPMVV = 3'b010;
    localparam logic [2:0] OPIVI = 3'b011;
    localparam logic [2:0] OPIVX = 3'b100;
    localparam logic [2:0] OPFVF = 3'b101;
    localparam logic [2:0] OPMVX = 3'b110;
    localparam logic [2:0] OPCFG = 3'b111;

    localparam logic [5:0] VWXUNARY0    = 6'b010000;
    localparam logic [5:0] VFWUNARY0    = 6'b010000;
    localparam logic [6:0] VSETVL_FUNC7 = 7'b1000000;

    // Legal {mew,width} encodings of vector loads/stores sharing the FP opcodes
    localparam int unsigned NumMemEnc = 8;
    localparam logic [NumMemEnc-1:0][3:0] VecMemEnc = {
        4'b0000, 4'b0101, 4'b0110, 4'b0111,
        4'b1000, 4'b1101, 4'b1110, 4'b1111
    };

    localparam int unsigned NumVecCsr = 7;
    localparam logic [NumVecCsr-1:0][11:0] VecCsr = {
        12'h008, 12'h009, 12'h00A, 12'h00F,
        12'hC20, 12'hC21, 12'hC22
    };

    function automatic logic is_vec_mem_enc(input logic [3:0] enc);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < NumMemEnc; i++) begin
            if (VecMemEnc[i] == enc) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic is_vec_csr(input logic [11:0] csr);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < NumVecCsr; i++) begin
            if (VecCsr[i] == csr) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/cva6_accel_predecode_unit.sv
// Combinational first-pass decode of one instruction into predecode flags.
// ARA_VAMO_PREDECODE_EN routes vector AMOs to the accelerator.
module cva6_accel_predecode_unit
    import ara_pkg::*;
(
    input  logic [31:0]      instr,
    output predecode_flags_t flags_c
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [5:0] func6;
    logic [6:0] func7;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign func6         = instr[31:26];
    assign func7         = instr[31:25];
    assign unused_fields = ^{instr[19:15], instr[11:7]};

    always_comb begin
        flags_c = '0;
        case (opcode)
            OpcodeVec: begin
                flags_c.accel = 1'b1;
                case (funct3)
                    OPFVV: begin
                        flags_c.vfp = 1'b1;
                        flags_c.fd  = (func6 == VFWUNARY0);
                    end
                    OPMVV: flags_c.rd = (func6 == VWXUNARY0);
                    OPIVX, OPMVX: flags_c.rs1 = 1'b1;
                    OPFVF: begin
                        flags_c.fs1 = 1'b1;
                        flags_c.vfp = 1'b1;
                    end
                    OPCFG: begin
                        flags_c.rs1 = 1'b1;
                        flags_c.rd  = 1'b1;
                        flags_c.cfg = 1'b1;
                        flags_c.rs2 = (func7 == VSETVL_FUNC7);
                    end
                    default: ;
                endcase
            end
            // Scalar FP loads/stores fall through with all flags clear
            OpcodeLoadFp, OpcodeStoreFp: begin
                if (is_vec_mem_enc({instr[28], funct3})) begin
                    flags_c.accel = 1'b1;
                    flags_c.rs1   = 1'b1;
                    flags_c.rs2   = (instr[27:26] == 2'b10);
                    flags_c.load  = (opcode == OpcodeLoadFp);
                    flags_c.store = (opcode == OpcodeStoreFp);
                end
            end
            OpcodeSystem: begin
                if ((funct3 inside {3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111})
                    && is_vec_csr(instr[31:20])) begin
                    flags_c.accel = 1'b1;
                    flags_c.rs1   = 1'b1;
                    flags_c.rs2   = 1'b1;
                    flags_c.rd    = 1'b1;
                end
            end
`ifdef ARA_VAMO_PREDECODE_EN
            OpcodeAmo: begin
                if (funct3 inside {3'b000, 3'b101, 3'b110, 3'b111}) begin
                    flags_c.accel = 1'b1;
                    flags_c.rs1   = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/cva6_accel_predecode_buffer.sv
// Predecoding instruction FIFO with outstanding-credit and vset* serialisation gating.
// ARA_VAMO_PREDECODE_EN (in the predecode unit) makes vector AMOs count as accelerator ops.
module cva6_accel_predecode_buffer
    import ara_pkg::*;
#(
    parameter int unsigned Depth          = 4,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic [31:0]         instr_i,
    input  logic                instr_valid_i,
    output logic                instr_ready_o,
    output logic [31:0]         out_instr_o,
    output predecode_flags_t    out_flags_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    input  logic                accel_done_i,
    input  logic                vcfg_done_i,
    output logic [CntWidth-1:0] outstanding_o,
    output logic                vcfg_pending_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned PtrFull  = PtrWidth + 1;

    typedef enum logic {IDLE, WAIT_CFG} vcfg_state_e;

    fifo_entry_t        mem [Depth];
    logic [PtrWidth:0]  wr_ptr, rd_ptr;
    fifo_entry_t        head;
    predecode_flags_t   dec_flags;
    vcfg_state_e        state;
    logic               full, empty, gated, push, pop, pop_accel;

    cva6_accel_predecode_unit u_predecode (
        .instr   (instr_i),
        .flags_c (dec_flags)
    );

    assign full  = (wr_ptr[PtrWidth] != rd_ptr[PtrWidth])
                && (wr_ptr[PtrWidth-1:0] == rd_ptr[PtrWidth-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[PtrWidth-1:0]];

    // Only accelerator heads wait on credits or a pending vset*; scalars always flow
    assign gated = head.flags.accel
                && ((outstanding_o == CntWidth'(MaxOutstanding)) || vcfg_pending_o);

    assign instr_ready_o  = !full;
    assign out_valid_o    = !empty && !gated;
    assign out_instr_o    = head.instr;
    assign out_flags_o    = head.flags;
    assign vcfg_pending_o = (state == WAIT_CFG);

    assign push      = instr_valid_i && !full;
    assign pop       = out_valid_o && out_ready_i;
    assign pop_accel = pop && head.flags.accel;

    // Storage and pointers; flush drops the FIFO contents including a same-cycle push
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < Depth; i++) mem[i] <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[PtrWidth-1:0]] <= '{instr: instr_i, flags: dec_flags};
                wr_ptr <= wr_ptr + PtrFull'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PtrFull'(1);
        end
    end

    // Issued-but-uncompleted accelerator instructions; flush leaves them alone
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_o <= '0;
        end else if (pop_accel && !accel_done_i) begin
            outstanding_o <= outstanding_o + CntWidth'(1);
        end else if (!pop_accel && accel_done_i && (outstanding_o != '0)) begin
            outstanding_o <= outstanding_o - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:     if (pop && head.flags.cfg) state <= WAIT_CFG;
                WAIT_CFG: if (vcfg_done_i) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    a_no_done_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(accel_done_i && !pop_accel && (outstanding_o == '0)));

endmodule

// File: tb/tb_cva6_accel_predecode_buffer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue model.
module tb_cva6_accel_predecode_buffer;
    import ara_pkg::*;

    localparam int unsigned Depth  = 4;
    localparam int unsigned MaxOut = 8;
    localparam int unsigned CntW   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             flush = 1'b0;
    logic [31:0]      instr = '0;
    logic             instr_valid = 1'b0;
    logic             instr_ready;
    logic [31:0]      out_instr;
    predecode_flags_t out_flags;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             accel_done = 1'b0;
    logic             vcfg_done = 1'b0;
    logic [CntW-1:0]  outstanding;
    logic             vcfg_pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cva6_accel_predecode_buffer #(.Depth(Depth), .MaxOutstanding(MaxOut)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .instr_i(instr), .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .out_instr_o(out_instr), .out_flags_o(out_flags), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .accel_done_i(accel_done), .vcfg_done_i(vcfg_done),
        .outstanding_o(outstanding), .vcfg_pending_o(vcfg_pending)
    );

    // ---------------- instruction builders and reference decode ----------------
    function automatic logic [31:0] mk_vop(input logic [5:0] f6, input logic [2:0] f3);
        return {f6, 1'b1, 5'd2, 5'd3, f3, 5'd4, 7'h57};
    endfunction
    function automatic logic [31:0] mk_vsetvli();
        return {1'b0, 11'h0D0, 5'd5, 3'b111, 5'd6, 7'h57};
    endfunction
    function automatic logic [31:0] mk_vle32();
        return {3'b000, 1'b0, 2'b00, 1'b1, 5'd0, 5'd10, 3'b110, 5'd8, 7'h07};
    endfunction
    function automatic logic [31:0] mk_addi(input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, 5'd1, 7'h13};
    endfunction
    function automatic logic [31:0] mk_amo(input logic [2:0] w);
        return {5'b00001, 1'b0, 1'b0, 5'd3, 5'd4, w, 5'd5, 7'h2F};
    endfunction

    // Flag word order: accel rs1 rs2 rd fs1 fs2 fd vfp load store cfg
    function automatic logic [10:0] ref_flags(input logic [31:0] i);
        bit a, r1, r2, rd, f1, fd, vf, ld, st, cf;
        logic [6:0] op;
        logic [2:0] f3;
        op = i[6:0];
        f3 = i[14:12];
        {a, r1, r2, rd, f1, fd, vf, ld, st, cf} = '0;
        if (op == 7'h57) begin
            a = 1;
            if (f3 == 3'd1) begin vf = 1; fd = (i[31:26] == 6'b010000); end
            if (f3 == 3'd2) rd = (i[31:26] == 6'b010000);
            if (f3 == 3'd4 || f3 == 3'd6) r1 = 1;
            if (f3 == 3'd5) begin f1 = 1; vf = 1; end
            if (f3 == 3'd7) begin r1 = 1; rd = 1; cf = 1; r2 = (i[31:25] == 7'b1000000); end
        end else if ((op == 7'h07 || op == 7'h27) &&
                     ({i[28], f3} inside {4'b0000, 4'b0101, 4'b0110, 4'b0111,
                                          4'b1000, 4'b1101, 4'b1110, 4'b1111})) begin
            a = 1; r1 = 1; r2 = (i[27:26] == 2'b10);
            ld = (op == 7'h07); st = (op == 7'h27);
        end else if (op == 7'h73 && (f3 inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7}) &&
                     (i[31:20] inside {12'h008, 12'h009, 12'h00A, 12'h00F,
                                       12'hC20, 12'hC21, 12'hC22})) begin
            a = 1; r1 = 1; r2 = 1; rd = 1;
        end
`ifdef ARA_VAMO_PREDECODE_EN
        else if (op == 7'h2F && (f3 inside {3'd0, 3'd5, 3'd6, 3'd7})) begin
            a = 1; r1 = 1;
        end
`endif
        return {a, r1, r2, rd, f1, 1'b0, fd, vf, ld, st, cf};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [11:0] vcsr [7];
        vcsr = '{12'h008, 12'h009, 12'h00A, 12'h00F, 12'hC20, 12'hC21, 12'hC22};
        r = $urandom;
        case ($urandom_range(0, 9))
            0, 1, 2: begin
                r[6:0] = 7'h57;
                if ($urandom_range(0, 1) == 1) r[31:26] = 6'b010000;
            end
            3: begin r[6:0] = 7'h57; r[14:12] = 3'b111; end
            4: r[6:0] = ($urandom_range(0, 1) == 1) ? 7'h07 : 7'h27;
            5: begin
                r[6:0] = 7'h73;
                if ($urandom_range(0, 2) != 0) r[31:20] = vcsr[$urandom_range(0, 6)];
            end
            6: r[6:0] = 7'h2F;
            default: r[6:0] = ($urandom_range(0, 1) == 1) ? 7'h13 : 7'h33;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        {instr_valid, out_ready, accel_done, vcfg_done, flush} = '0;
        instr = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        {instr_valid, out_ready, accel_done, vcfg_done, flush} = '0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b exp 0", out_valid); end
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b exp 1", instr_ready); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h exp 0", out_instr); end
        checks++; if (out_flags !== 11'h0) begin errors++; $display("FAIL reset_flags: got %b exp 0", out_flags); end
        checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", outstanding); end
        checks++; if (vcfg_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %0b exp 0", vcfg_pending); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL reset_release: valid %0b ready %0b exp 0/1", out_valid, instr_ready); end
    endtask

    task automatic test_vadd_vx();
        logic [31:0] v;
        do_reset();
        v = mk_vop(6'b000000, 3'b100);
        instr = v; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL vadd_valid: got %0b exp 1", out_valid); end
        checks++; if (out_instr !== v) begin errors++; $display("FAIL vadd_instr: got %h exp %h", out_instr, v); end
        checks++; if (out_flags !== 11'b110_0000_0000) begin errors++; $display("FAIL vadd_flags: got %b exp 11000000000", out_flags); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (outstanding !== 4'd1) begin errors++; $display("FAIL vadd_cnt: got %0d exp 1", outstanding); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL vadd_empty: got %0b exp 0", out_valid); end
        accel_done = 1'b1;
        tick();
        accel_done = 1'b0;
        checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL vadd_done: got %0d exp 0", outstanding); end
    endtask

    task automatic test_vset_serialise();
        do_reset();
        instr = mk_vsetvli(); instr_valid = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_flags !== 11'b110_1000_0001) begin errors++; $display("FAIL vset_head: valid %0b flags %b exp 1/11010000001", out_valid, out_flags); end
        instr = mk_vle32(); out_ready = 1'b1;
        tick();
        instr_valid = 1'b0;
        checks++; if (vcfg_pending !== 1'b1) begin errors++; $display("FAIL vset_pending: got %0b exp 1", vcfg_pending); end
        checks++; if (outstanding !== 4'd1) begin errors++; $display("FAIL vset_cnt: got %0d exp 1", outstanding); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (out_valid !== 1'b0 || out_instr !== mk_vle32()) begin errors++; $display("FAIL vle_held: valid %0b instr %h exp 0/%h", out_valid, out_instr, mk_vle32()); end
            tick();
        end
        vcfg_done = 1'b1;
        out_ready = 1'b0;
        tick();
        vcfg_done = 1'b0;
        checks++; if (vcfg_pending !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL vle_release: pending %0b valid %0b exp 0/1", vcfg_pending, out_valid); end
        checks++; if (out_flags !== 11'b110_0000_0100) begin errors++; $display("FAIL vle_flags: got %b exp 11000000100", out_flags); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (outstanding !== 4'd2 || out_valid !== 1'b0) begin errors++; $display("FAIL vle_issue: cnt %0d valid %0b exp 2/0", outstanding, out_valid); end
    endtask

    task automatic test_credit_limit();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            instr = mk_vop(6'(k), 3'b000); instr_valid = 1'b1;
            tick();
        end
        instr_valid = 1'b0;
        tick();
        checks++; if (outstanding !== 4'd8) begin errors++; $display("FAIL credit_full: got %0d exp 8", outstanding); end
        instr = mk_vop(6'h3, 3'b000); instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL credit_hold: got %0b exp 0", out_valid); end
            tick();
        end
        accel_done = 1'b1; out_ready = 1'b0;
        tick();
        accel_done = 1'b0;
        checks++; if (outstanding !== 4'd7 || out_valid !== 1'b1) begin errors++; $display("FAIL credit_free: cnt %0d valid %0b exp 7/1", outstanding, out_valid); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (outstanding !== 4'd8) begin errors++; $display("FAIL credit_refill: got %0d exp 8", outstanding); end
        instr = mk_addi(12'd7); instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL scalar_ungated: got %0b exp 1", out_valid); end
        accel_done = 1'b1; out_ready = 1'b1;
        tick();
        accel_done = 1'b0;
        checks++; if (outstanding !== 4'd7 || out_valid !== 1'b0) begin errors++; $display("FAIL addi_done: cnt %0d valid %0b exp 7/0", outstanding, out_valid); end
        instr = mk_vop(6'h0, 3'b000); instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL credit_next: got %0b exp 1", out_valid); end
        tick();
        out_ready = 1'b0;
        checks++; if (outstanding !== 4'd8) begin errors++; $display("FAIL credit_back8: got %0d exp 8", outstanding); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            instr = mk_addi(12'(i + 1)); instr_valid = 1'b1;
            tick();
        end
        instr_valid = 1'b0;
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b exp 0", instr_ready); end
        instr = mk_addi(12'd99); instr_valid = 1'b1; out_ready = 1'b1;
        tick();
        instr_valid = 1'b0; out_ready = 1'b0;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready: got %0b exp 1", instr_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || out_instr !== mk_addi(12'(i + 2))) begin errors++; $display("FAIL full_drain: valid %0b instr %h exp 1/%h", out_valid, out_instr, mk_addi(12'(i + 2))); end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_refused: got %0b exp 0", out_valid); end
        for (int r = 0; r < 3; r++) begin
            out_ready = 1'b0;
            for (int i = 0; i < 4; i++) begin
                instr = mk_addi(12'(16 * r + i)); instr_valid = 1'b1;
                tick();
            end
            instr_valid = 1'b0;
            checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL wrap_full: round %0d ready %0b exp 0", r, instr_ready); end
            out_ready = 1'b1;
            for (int i = 0; i < 4; i++) begin
                checks++; if (out_instr !== mk_addi(12'(16 * r + i))) begin errors++; $display("FAIL wrap_order: got %h exp %h", out_instr, mk_addi(12'(16 * r + i))); end
                tick();
            end
            checks++; if (out_valid !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL wrap_empty: valid %0b ready %0b exp 0/1", out_valid, instr_ready); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b1;
        instr = mk_vop(6'h0, 3'b000); instr_valid = 1'b1;
        tick();
        tick();
        instr_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        checks++; if (outstanding !== 4'd2) begin errors++; $display("FAIL flush_pre_cnt: got %0d exp 2", outstanding); end
        for (int i = 0; i < 3; i++) begin
            instr = mk_addi(12'(i)); instr_valid = 1'b1;
            tick();
        end
        flush = 1'b1; instr = mk_vop(6'h1, 3'b000);
        tick();
        flush = 1'b0; instr_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL flush_empty: valid %0b ready %0b exp 0/1", out_valid, instr_ready); end
        checks++; if (outstanding !== 4'd2) begin errors++; $display("FAIL flush_cnt: got %0d exp 2", outstanding); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_discard: got %0b exp 0", out_valid); end
        instr = mk_vsetvli(); instr_valid = 1'b1; out_ready = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        instr = mk_addi(12'd5); instr_valid = 1'b1; out_ready = 1'b0;
        tick();
        instr_valid = 1'b0;
        checks++; if (vcfg_pending !== 1'b1 || out_valid !== 1'b1 || outstanding !== 4'd3) begin errors++; $display("FAIL prereset: pending %0b valid %0b cnt %0d exp 1/1/3", vcfg_pending, out_valid, outstanding); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL async_rst_hs: valid %0b ready %0b exp 0/1", out_valid, instr_ready); end
        checks++; if (out_instr !== 32'h0 || out_flags !== 11'h0) begin errors++; $display("FAIL async_rst_data: instr %h flags %b exp 0", out_instr, out_flags); end
        checks++; if (outstanding !== 4'd0 || vcfg_pending !== 1'b0) begin errors++; $display("FAIL async_rst_state: cnt %0d pending %0b exp 0/0", outstanding, vcfg_pending); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_amo();
        logic [10:0] exp_f;
        logic [3:0]  exp_c;
`ifdef ARA_VAMO_PREDECODE_EN
        exp_f = 11'b110_0000_0000; exp_c = 4'd1;
`else
        exp_f = 11'b000_0000_0000; exp_c = 4'd0;
`endif
        do_reset();
        instr = mk_amo(3'b110); instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_flags !== exp_f) begin errors++; $display("FAIL amo_flags: valid %0b flags %b exp 1/%b", out_valid, out_flags, exp_f); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (outstanding !== exp_c) begin errors++; $display("FAIL amo_cnt: got %0d exp %0d", outstanding, exp_c); end
    endtask

    // ---------------- randomized traffic against a queue model ----------------
    task automatic test_random();
        logic [31:0] q[$];
        int          m_cnt;
        bit          m_wait, m_valid, m_ready, m_pop, pacc, pcfg;
        logic [10:0] hf;
        bit          r_push, r_ready, r_done, r_vdone, r_flush;
        logic [31:0] r_instr;
        do_reset();
        q.delete(); m_cnt = 0; m_wait = 0;
        for (int c = 0; c < 1500; c++) begin
            hf = (q.size() > 0) ? ref_flags(q[0]) : 11'h0;
            m_valid = (q.size() > 0) && !(hf[10] && (m_cnt == MaxOut || m_wait));
            m_ready = (q.size() < Depth);
            checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid c%0d: got %0b exp %0b", c, out_valid, m_valid); end
            checks++; if (instr_ready !== m_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %0b exp %0b", c, instr_ready, m_ready); end
            checks++; if (outstanding !== 4'(m_cnt)) begin errors++; $display("FAIL rnd_cnt c%0d: got %0d exp %0d", c, outstanding, m_cnt); end
            checks++; if (vcfg_pending !== m_wait) begin errors++; $display("FAIL rnd_pending c%0d: got %0b exp %0b", c, vcfg_pending, m_wait); end
            if (q.size() > 0) begin
                checks++; if (out_instr !== q[0] || out_flags !== hf) begin errors++; $display("FAIL rnd_head c%0d: instr %h flags %b exp %h/%b", c, out_instr, out_flags, q[0], hf); end
            end
            r_push  = ($urandom_range(0, 99) < 60);
            r_instr = rand_instr();
            r_ready = ($urandom_range(0, 99) < 60);
            r_done  = (m_cnt > 0) && ($urandom_range(0, 99) < 25);
            r_vdone = ($urandom_range(0, 99) < 20);
            r_flush = ($urandom_range(0, 99) < 3);
            instr = r_instr; instr_valid = r_push; out_ready = r_ready;
            accel_done = r_done; vcfg_done = r_vdone; flush = r_flush;
            m_pop = m_valid && r_ready;
            pacc = m_pop && hf[10];
            pcfg = m_pop && hf[0];
            if (m_pop) void'(q.pop_front());
            if (r_flush) q.delete();
            else if (r_push && m_ready) q.push_back(r_instr);
            if (pacc && !r_done) m_cnt++;
            else if (!pacc && r_done && m_cnt > 0) m_cnt--;
            if (m_wait) begin
                if (r_vdone) m_wait = 0;
            end else if (pcfg) begin
                m_wait = 1;
            end
            tick();
        end
        {instr_valid, out_ready, accel_done, vcfg_done, flush} = '0;
    endtask

    initial begin
        test_reset();
        test_vadd_vx();
        test_vset_serialise();
        test_credit_limit();
        test_full_wrap();
        test_flush();
        test_amo();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
